adder_checker: RTL and testbench
================================

Name: adder_checker

Overview:
- Synthesizable, self-checking stimulus/response stage that wraps the 1-bit full adder under test.
- Upstream side: drives the three adder inputs t1, t2, t3 through all 8 combinations in a clocked sequence.
- Downstream side: samples the adder outputs p1 (sum) and p2 (carry), compares them against a golden model, and reports an error count, first failing vector and pass/fail.
- Replaces the time-delay stimulus with hardware that runs on a board or in a clocked bench.

Parameters:
- HOLD_CYCLES, 10: clock cycles each vector is held before sampling; legal range 2..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to run a full sweep.
- t1  out  1  adder input a; equals vec[2].
- t2  out  1  adder input b; equals vec[1].
- t3  out  1  adder carry-in; equals vec[0].
- p1  in  1  adder sum output.
- p2  in  1  adder carry output.
- busy  out  1  high while a sweep is running.
- done  out  1  high from sweep end until the next start or reset.
- pass  out  1  valid when done=1; 1 if err_count==0.
- err_count  out  4  number of mismatching vectors, 0..8.
- first_err_valid  out  1  set on the first mismatch of a sweep.
- first_err_vec  out  3  vec index of the first mismatch.

Behaviour:
- Reset (asynchronous, any state, including mid-sweep):
  - state=IDLE; vec=0; t1/t2/t3=0; hold counter=0.
  - busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_vec=0.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - start=1 → DRIVE next cycle; vec=0, counter=0, all results cleared.
- DRIVE:
  - busy=1; t outputs driven from vec (registered).
  - Counter increments each cycle.
  - When counter==HOLD_CYCLES-1 → CHECK.
- CHECK (one cycle):
  - Sample p1/p2 against exp_sum = t1^t2^t3 and exp_carry = majority(t1,t2,t3).
  - On mismatch: err_count+1; if first_err_valid==0, capture vec and set first_err_valid.
  - If vec==7 → DONE; otherwise vec+1, counter=0 → DRIVE.
- Vector timing: each vector occupies HOLD_CYCLES+1 cycles; the t outputs change only on the CHECK→DRIVE transition.
- Sweep length: start to done=1 is exactly 8*(HOLD_CYCLES+1)+1 cycles (start-capture cycle included).
- DONE:
  - busy=0, done=1; pass = (err_count==0).
  - t outputs hold the last vector, 3'b111.
  - start=1 → behaves as in IDLE: clears results and begins a new sweep; done drops the next cycle.
- start while busy: ignored; no restart and no effect on counters.
- start and reset together: reset wins.
- Vector wrap: vec never wraps within a sweep; 7 is terminal.
- err_count needs no saturation (max 8 fits in 4 bits).
- All outputs are registered; there is no combinational path from p1/p2 to any output.

Decomposition:
- Shared constants header (adder_pkg.vh):
  - state encodings ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_CHECK=2'd2, ST_DONE=2'd3.
  - NUM_VEC=8.
- One combinational sub-module, adder_ref_model: inputs a, b, cin; outputs sum, cout; the golden full adder.
- The checker instantiates adder_ref_model on the registered t outputs.

Test Plan:
- Correct adder: connect a correct full adder, HOLD_CYCLES=10, pulse start → done=1 after 89 cycles; pass=1, err_count=0, first_err_valid=0; t sequence 000,001,…,111 with each value held 11 cycles.
- Stuck sum: tie p1=0, with p2 from a correct adder → err_count=4 (vectors 1,2,4,7), first_err_vec=1, pass=0.
- Inverted carry: invert the carry output → err_count=8, first_err_vec=0, pass=0.
- Reset mid-run: assert rst during vector 5 DRIVE → all outputs 0 in the same cycle (asynchronous); after release, state=IDLE; the next start runs a clean sweep with pass=1.
- Start handling: pulse start again during vector 3 → no restart; sweep ends at the normal cycle count. A start in DONE → done=0 next cycle, err_count cleared, t=000.
- Minimum hold: HOLD_CYCLES=2 with a correct adder → done after 25 cycles, pass=1.

Source files
------------

// File: rtl/adder_checker_pkg.sv
// rtl/adder_checker_pkg.sv - shared constants for the full-adder checker
// Purpose: FSM state encodings, vector count and vector type used by
//          adder_checker and its testbench. No ports.
package adder_checker_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int NUM_VEC = 8;

  typedef logic [2:0] vec_t;

  localparam vec_t LAST_VEC = vec_t'(NUM_VEC - 1);

endpackage

// File: rtl/adder_checker_if.sv
// rtl/adder_checker_if.sv - bus between the checker and the adder under test
// Purpose: carries the adder stimulus and response.
// Signals: t1/t2/t3 adder inputs a/b/cin, p1 sum, p2 carry.
// Modports: master = checker (drives t, reads p); slave = adder under test.
interface adder_checker_if;

  logic t1;
  logic t2;
  logic t3;
  logic p1;
  logic p2;

  modport master (output t1, t2, t3, input p1, p2);
  modport slave  (input t1, t2, t3, output p1, p2);

endinterface

// File: rtl/adder_ref_model.sv
// rtl/adder_ref_model.sv - golden 1-bit full adder
// Purpose: combinational reference the checker compares the DUT against.
// Ports: a, b, cin in; sum, cout out.
module adder_ref_model (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_checker.sv
// rtl/adder_checker.sv - clocked stimulus/response checker for a full adder
// Purpose: on start, sweeps all 8 input vectors, holds each HOLD_CYCLES
//          cycles, then checks sum/carry against a golden model.
// Ports: clk, rst (async, active-high), start;
//        bus (master: t1/t2/t3 out, p1/p2 in);
//        busy, done, pass, err_count[3:0], first_err_valid, first_err_vec[2:0].
module adder_checker
  import adder_checker_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  adder_checker_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [3:0]             err_count,
  output logic                   first_err_valid,
  output logic [2:0]             first_err_vec
);

  logic [1:0]       state;
  vec_t             vec;
  logic [CNT_W-1:0] cnt;

  logic ref_sum;
  logic ref_cout;
  logic mismatch;
  logic [3:0] err_next;

  // vec is a register, so the t outputs are registered and only change
  // when vec advances on CHECK -> DRIVE (or is cleared by start/reset).
  assign bus.t1 = vec[2];
  assign bus.t2 = vec[1];
  assign bus.t3 = vec[0];

  adder_ref_model u_ref (
    .a    (vec[2]),
    .b    (vec[1]),
    .cin  (vec[0]),
    .sum  (ref_sum),
    .cout (ref_cout)
  );

  always_comb begin
    mismatch = (bus.p1 != ref_sum) || (bus.p2 != ref_cout);
    err_next = err_count + {3'b000, mismatch};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      vec             <= '0;
      cnt             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_DRIVE;
            vec             <= '0;
            cnt             <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
          end
        end
        ST_DRIVE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          err_count <= err_next;
          if (mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_vec   <= vec;
          end
          if (vec == LAST_VEC) begin
            // vec stays at 7 so the t outputs hold the last vector in DONE
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 4'd0);
          end else begin
            vec   <= vec + vec_t'(1);
            cnt   <= '0;
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_checker.sv
// tb/tb_adder_checker.sv - self-checking bench for adder_checker
module tb_adder_checker;

  typedef struct {
    logic       stuck;
    logic [7:0] sm;
    logic [7:0] cm;
    int         exp_err;
    int         exp_first;
    int         exp_fv;
    int         exp_pass;
  } vec_rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start10;
  logic       start2;
  logic       stuck_sum;
  logic [7:0] smask;
  logic [7:0] cmask;

  logic       busy10, done10, pass10, fev10;
  logic [3:0] err10;
  logic [2:0] fvec10;
  logic       busy2, done2, pass2, fev2;
  logic [3:0] err2;
  logic [2:0] fvec2;

  int checks = 0;
  int errors = 0;

  adder_checker_if bus10 ();
  adder_checker_if bus2 ();

  adder_checker #(.HOLD_CYCLES(10), .CNT_W(8)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .bus(bus10.master),
    .busy(busy10), .done(done10), .pass(pass10), .err_count(err10),
    .first_err_valid(fev10), .first_err_vec(fvec10)
  );

  adder_checker #(.HOLD_CYCLES(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bus(bus2.master),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_valid(fev2), .first_err_vec(fvec2)
  );

  // Adder under test: arithmetic full adder with optional faults.
  function automatic logic [1:0] faulty(logic [2:0] v, logic stuck, logic [7:0] sm, logic [7:0] cm);
    int total;
    logic s;
    logic c;
    total = int'(v[2]) + int'(v[1]) + int'(v[0]);
    s = (total % 2) == 1;
    c = (total / 2) == 1;
    return {c ^ cm[v], stuck ? 1'b0 : (s ^ sm[v])};
  endfunction

  assign {bus10.p2, bus10.p1} = faulty({bus10.t1, bus10.t2, bus10.t3}, stuck_sum, smask, cmask);
  assign {bus2.p2, bus2.p1}   = faulty({bus2.t1, bus2.t2, bus2.t3}, stuck_sum, smask, cmask);

  // Expected sweep result: walk all vectors, compare faulty adder to true arithmetic.
  function automatic vec_rec_t model(logic stuck, logic [7:0] sm, logic [7:0] cm);
    vec_rec_t r;
    logic [1:0] got;
    int total;
    r.stuck = stuck; r.sm = sm; r.cm = cm;
    r.exp_err = 0; r.exp_first = 0; r.exp_fv = 0;
    for (int v = 0; v < 8; v++) begin
      total = (v / 4) + ((v / 2) % 2) + (v % 2);
      got = faulty(3'(v), stuck, sm, cm);
      if (int'(got[0]) != total % 2 || int'(got[1]) != total / 2) begin
        if (r.exp_fv == 0) begin
          r.exp_fv = 1;
          r.exp_first = v;
        end
        r.exp_err++;
      end
    end
    r.exp_pass = (r.exp_err == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sweep10(input int restart_at, input vec_rec_t e);
    int n;
    @(negedge clk);
    start10 = 1'b1;
    @(posedge clk); #1;
    start10 = 1'b0;
    n = 1;
    while (!done10 && n < 150) begin
      chk("t_seq10", int'({bus10.t1, bus10.t2, bus10.t3}), (n - 1) / 11);
      chk("busy10", int'(busy10), 1);
      start10 = (n == restart_at);
      @(posedge clk); #1;
      n++;
    end
    start10 = 1'b0;
    chk("sweep_len10", n, 89);
    chk("done10", int'(done10), 1);
    chk("busy_end10", int'(busy10), 0);
    chk("err_count10", int'(err10), e.exp_err);
    chk("first_valid10", int'(fev10), e.exp_fv);
    chk("first_vec10", int'(fvec10), e.exp_first);
    chk("pass10", int'(pass10), e.exp_pass);
    chk("t_hold10", int'({bus10.t1, bus10.t2, bus10.t3}), 7);
  endtask

  task automatic sweep2(input vec_rec_t e);
    int n;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 1;
    while (!done2 && n < 60) begin
      chk("t_seq2", int'({bus2.t1, bus2.t2, bus2.t3}), (n - 1) / 3);
      @(posedge clk); #1;
      n++;
    end
    chk("sweep_len2", n, 25);
    chk("err_count2", int'(err2), e.exp_err);
    chk("first_vec2", int'(fvec2), e.exp_first);
    chk("pass2", int'(pass2), e.exp_pass);
  endtask

  vec_rec_t tbl[5];
  vec_rec_t clean;
  vec_rec_t rnd;

  initial begin
    rst = 1'b1; start10 = 1'b0; start2 = 1'b0;
    stuck_sum = 1'b0; smask = '0; cmask = '0;
    clean = model(1'b0, 8'h00, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy10), 0);
    chk("rst_done", int'(done10), 0);
    chk("rst_pass", int'(pass10), 0);
    chk("rst_err", int'(err10), 0);
    chk("rst_fev", int'(fev10), 0);
    chk("rst_fvec", int'(fvec10), 0);
    chk("rst_t", int'({bus10.t1, bus10.t2, bus10.t3}), 0);
    chk("rst_done2", int'(done2), 0);
    @(negedge clk);
    rst = 1'b0;

    tbl[0] = '{1'b0, 8'h00, 8'h00, 0, 0, 0, 1};
    tbl[1] = '{1'b1, 8'h00, 8'h00, 4, 1, 1, 0};
    tbl[2] = '{1'b0, 8'h00, 8'hff, 8, 0, 1, 0};
    tbl[3] = '{1'b0, 8'h80, 8'h00, 1, 7, 1, 0};
    tbl[4] = '{1'b0, 8'h04, 8'h24, 2, 2, 1, 0};
    for (int i = 0; i < 5; i++) begin
      stuck_sum = tbl[i].stuck; smask = tbl[i].sm; cmask = tbl[i].cm;
      sweep10(0, tbl[i]);
    end

    // start while in DONE: results clear and a new sweep begins
    @(negedge clk);
    start10 = 1'b1;
    @(posedge clk); #1;
    start10 = 1'b0;
    chk("restart_done", int'(done10), 0);
    chk("restart_busy", int'(busy10), 1);
    chk("restart_err", int'(err10), 0);
    chk("restart_fev", int'(fev10), 0);
    chk("restart_t", int'({bus10.t1, bus10.t2, bus10.t3}), 0);
    begin
      int k;
      k = 0;
      while (!done10 && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      chk("restart_finish", int'(done10), 1);
      chk("restart_err_end", int'(err10), 2);
    end

    // start pulse during vector 3 must be ignored
    stuck_sum = 1'b0; smask = '0; cmask = '0;
    sweep10(37, clean);

    // asynchronous reset during vector 5
    begin
      int n;
      @(negedge clk);
      start10 = 1'b1;
      @(posedge clk); #1;
      start10 = 1'b0;
      n = 1;
      while (n < 58) begin
        @(posedge clk); #1;
        n++;
      end
      chk("pre_rst_vec", int'({bus10.t1, bus10.t2, bus10.t3}), 5);
      rst = 1'b1;
      #1;
      chk("arst_busy", int'(busy10), 0);
      chk("arst_t", int'({bus10.t1, bus10.t2, bus10.t3}), 0);
      chk("arst_done", int'(done10), 0);
      chk("arst_err", int'(err10), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", int'(busy10), 0);
      chk("idle_done", int'(done10), 0);
    end
    sweep10(0, clean);

    // randomized fault patterns against the model
    for (int i = 0; i < 4; i++) begin
      stuck_sum = ($urandom % 4) == 0;
      smask = 8'($urandom);
      cmask = 8'($urandom & $urandom);
      rnd = model(stuck_sum, smask, cmask);
      sweep10(0, rnd);
    end

    // minimum hold
    stuck_sum = 1'b0; smask = '0; cmask = '0;
    sweep2(clean);
    smask = 8'($urandom);
    cmask = 8'($urandom);
    rnd = model(1'b0, smask, cmask);
    sweep2(rnd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
